spi_command_receiver: RTL and testbench
=======================================

# spi_command_receiver

SPI-mode-0 slave front end that produces the engine's command byte stream. It deserialises MOSI bytes from the host MCU into single-cycle `command_out`/`command_out_ready` strobes, which connect directly to the engine's `command_in`/`command_in_ready` FIFO write port. In the same transfer it shifts a status byte back on MISO so the host can pace writes against FIFO occupancy. All SPI pins are asynchronous to `clk` and are synchronised internally.

## Interface
Parameters:
- `spi_fifo_length`, 32, depth of the engine command FIFO; used for the overrun check.
- `count_width`, `$clog2(spi_fifo_length)+1`, width of `fifo_count`.
- `sync_stages`, 2, flip-flop stages on each SPI input, minimum 2.

Ports:
- `clk` in 1, system clock; must be ≥ 8× SCLK.
- `reset_n` in 1, reset, asynchronous, active-low.
- `spi_sclk` in 1, SPI clock, idle low.
- `spi_cs_n` in 1, chip select, active-low.
- `spi_mosi` in 1, host→FPGA data, MSB first.
- `spi_miso` out 1, FPGA→host status data, MSB first.
- `command_out` out 8, last completed byte.
- `command_out_ready` out 1, one-cycle write strobe for `command_out`.
- `fifo_count` in `count_width`, engine FIFO occupancy.
- `invalid_command` in 1, controller invalid flag; any high cycle sets the sticky flag.
- `overrun` out 1, one-cycle pulse when a byte is dropped because the FIFO is full.
- `frame_error` out 1, one-cycle pulse when CS rises mid-byte.

## Operation
- **Synchronisers and edge detect.** SCLK, CS_n and MOSI each pass through `sync_stages` flip-flops.
  - Registered edge detect produces `sclk_rise`, `sclk_fall`, `cs_fall` and `cs_rise` from the synchronised signals.
  - MOSI is sampled from its synchronised copy on `sclk_rise`.
- **States.**
  - `DISARMED`, entered from reset: waits for synchronised CS_n high, then goes to `IDLE`. A transfer already in progress when reset is released is ignored entirely.
  - `IDLE`: on `cs_fall`, clear the 3-bit bit counter, load the status byte into the MISO shift register, and go to `ACTIVE`.
  - `ACTIVE`:
    - On `sclk_rise`, shift MOSI into the RX register and increment the bit counter.
    - On `sclk_fall`, shift the MISO register left.
    - When the 8th bit is received, complete the byte, wrap the counter to 0, and reload the status byte for the next byte.
    - On `cs_rise`, go to `IDLE`.
  - SCLK edges outside `ACTIVE` are ignored.
  - A `cs_fall` and an SCLK edge in the same cycle: `cs_fall` wins and the SCLK edge is dropped.
- **Byte completion.**
  - If `fifo_count < spi_fifo_length`:
    - Register the byte onto `command_out` and pulse `command_out_ready` for one cycle.
    - `command_out` holds that value until the next accepted byte.
  - Otherwise, drop the byte, leave `command_out` unchanged, pulse `overrun`, and set `overrun_sticky`.
- **Frame error.** `cs_rise` with a non-zero bit counter discards the partial byte and pulses `frame_error`. No `command_out_ready` is issued.
- **Status byte.**
  - bit7 is `invalid_sticky`.
  - bit6 is `overrun_sticky`.
  - bits5:0 are `fifo_count`, saturated at 63.
  - The status byte is captured at load time, i.e. at `cs_fall` or at byte completion.
- **Sticky flags.**
  - Both sticky flags clear on completion of a byte whose status had either flag set, because the host has read them.
  - A set event in the same cycle as a clear wins; the flag stays set.
- **MISO.** Drives the MSB of the shift register while in `ACTIVE`, and drives 0 otherwise.

## Timing
- Reset values:
  - `spi_miso`=0, `command_out`=8'h00, `command_out_ready`=0, `overrun`=0, `frame_error`=0.
  - Both sticky flags 0; state `DISARMED`.
- Detect latency: `sclk_rise` is asserted `sync_stages`+1 cycles after the first `clk` edge that samples raw SCLK high. The same applies to other edges.
- `command_out_ready` asserts in the cycle after the 8th `sclk_rise` is detected. Input-to-strobe latency is therefore `sync_stages`+2 cycles.
- `overrun` and `frame_error` follow the same one-cycle-after-detect rule.
- MISO changes `sync_stages`+2 cycles after the SCLK falling edge. The host must keep the SCLK half-period above that interval.
- The first status MSB is valid `sync_stages`+2 cycles after CS_n falls. The host needs CS-to-first-SCLK setup of at least that.
- The `fifo_count` comparison uses the value present in the completion cycle. There is no look-ahead for the strobe being issued.
- Reset asserted mid-byte: all outputs go to reset values asynchronously and the partial byte is lost. After release the block stays in `DISARMED` until CS_n goes high.

## Test plan
- Reset release with CS_n high → transfer of 0xA5 → `command_out`=0xA5 with a single `command_out_ready` pulse `sync_stages`+2 cycles after the 8th rising edge; MISO shifts 0x00 (empty FIFO, no flags).
- `fifo_count`=32 → send 0x3C → no strobe, `overrun` pulse, `command_out` unchanged; the next byte's MISO status is 0x60; the byte after that reads 0x20 (sticky cleared).
- Pulse `invalid_command` for 1 cycle, then run a 2-byte transfer with `fifo_count`=5 → first status 0x85, second status 0x05.
- Deassert CS_n after 5 bits → `frame_error` pulse, no strobe; the next full byte 0x11 is received correctly.
- Assert reset mid-byte with CS_n low, release it, then clock more bits → nothing is accepted until CS_n goes high; a following transfer of 0xFF, 0x00, 0x7E produces 3 strobes in that order.
- CS_n fall coincident with an SCLK rising edge → that edge is ignored; the byte is assembled only from the subsequent 8 edges.

Source files
------------

// File: rtl/spi_command_receiver.sv
// SPI mode-0 slave that turns host MOSI bytes into engine command strobes and returns a
// status byte (sticky error flags plus FIFO occupancy) on MISO during the same transfer.
module spi_command_receiver #(
  parameter int unsigned spi_fifo_length = 32,
  parameter int unsigned count_width     = $clog2(spi_fifo_length) + 1,
  parameter int unsigned sync_stages     = 2
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   spi_sclk,
  input  logic                   spi_cs_n,
  input  logic                   spi_mosi,
  output logic                   spi_miso,
  output logic [7:0]             command_out,
  output logic                   command_out_ready,
  input  logic [count_width-1:0] fifo_count,
  input  logic                   invalid_command,
  output logic                   overrun,
  output logic                   frame_error
);

  typedef enum logic [1:0] {StDisarmed, StIdle, StActive} state_e;

  state_e state_q, state_d;

  logic [sync_stages-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic sclk_s, cs_s, mosi_s;
  logic sclk_prev_q, cs_prev_q;
  logic sclk_rise_q, sclk_fall_q, cs_rise_q, cs_fall_q;

  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [6:0] rx_q, rx_d;
  logic [7:0] miso_sr_q, miso_sr_d;
  logic [1:0] sent_flags_q, sent_flags_d;
  logic       inv_sticky_q, inv_sticky_d;
  logic       ovr_sticky_q, ovr_sticky_d;
  logic [7:0] command_out_d;
  logic       command_out_ready_d, overrun_d, frame_error_d;

  logic [7:0]  rx_byte;
  logic [7:0]  status;
  logic [5:0]  cnt_sat;
  logic [31:0] cnt_ext;
  logic        fifo_ok, ovr_set, flag_clear, load;

  assign sclk_s = sclk_sync_q[sync_stages-1];
  assign cs_s   = cs_sync_q[sync_stages-1];
  assign mosi_s = mosi_sync_q[sync_stages-1];

  // CS_n chain resets low so a transfer already running at reset release is never armed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '0;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b0;
      sclk_rise_q <= 1'b0;
      sclk_fall_q <= 1'b0;
      cs_rise_q   <= 1'b0;
      cs_fall_q   <= 1'b0;
    end else begin
      sclk_sync_q <= {sclk_sync_q[sync_stages-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[sync_stages-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[sync_stages-2:0], spi_mosi};
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      sclk_rise_q <= sclk_s & ~sclk_prev_q;
      sclk_fall_q <= ~sclk_s & sclk_prev_q;
      cs_rise_q   <= cs_s & ~cs_prev_q;
      cs_fall_q   <= ~cs_s & cs_prev_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StDisarmed;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StDisarmed: if (cs_s) state_d = StIdle;
      StIdle:     if (cs_fall_q) state_d = StActive;
      StActive:   if (cs_rise_q) state_d = StIdle;
      default:    state_d = StDisarmed;
    endcase
  end

  always_comb begin
    cnt_ext = 32'(fifo_count);
    cnt_sat = (cnt_ext > 32'd63) ? 6'h3f : cnt_ext[5:0];
    fifo_ok = cnt_ext < spi_fifo_length;

    bit_cnt_d           = bit_cnt_q;
    rx_d                = rx_q;
    miso_sr_d           = miso_sr_q;
    sent_flags_d        = sent_flags_q;
    command_out_d       = command_out;
    command_out_ready_d = 1'b0;
    overrun_d           = 1'b0;
    frame_error_d       = 1'b0;
    rx_byte             = {rx_q, mosi_s};
    ovr_set             = 1'b0;
    flag_clear          = 1'b0;
    load                = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (cs_fall_q) begin
          bit_cnt_d = 3'd0;
          load      = 1'b1;
        end
      end
      StActive: begin
        if (cs_rise_q) begin
          frame_error_d = (bit_cnt_q != 3'd0);
        end else if (sclk_rise_q) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (fifo_ok) begin
              command_out_d       = rx_byte;
              command_out_ready_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
              ovr_set   = 1'b1;
            end
            flag_clear = |sent_flags_q;
            load       = 1'b1;
          end
        end else if (sclk_fall_q && bit_cnt_q != 3'd0) begin
          // The fall right after a load presents the new MSB, so it must not shift.
          miso_sr_d = {miso_sr_q[6:0], 1'b0};
        end
      end
      default: ;
    endcase

    // Set events take priority over the read-clear.
    inv_sticky_d = invalid_command | (inv_sticky_q & ~flag_clear);
    ovr_sticky_d = ovr_set | (ovr_sticky_q & ~flag_clear);
    status       = {inv_sticky_d, ovr_sticky_d, cnt_sat};
    if (load) begin
      miso_sr_d    = status;
      sent_flags_d = status[7:6];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt_q         <= 3'd0;
      rx_q              <= 7'd0;
      miso_sr_q         <= 8'd0;
      sent_flags_q      <= 2'd0;
      inv_sticky_q      <= 1'b0;
      ovr_sticky_q      <= 1'b0;
      command_out       <= 8'h00;
      command_out_ready <= 1'b0;
      overrun           <= 1'b0;
      frame_error       <= 1'b0;
    end else begin
      bit_cnt_q         <= bit_cnt_d;
      rx_q              <= rx_d;
      miso_sr_q         <= miso_sr_d;
      sent_flags_q      <= sent_flags_d;
      inv_sticky_q      <= inv_sticky_d;
      ovr_sticky_q      <= ovr_sticky_d;
      command_out       <= command_out_d;
      command_out_ready <= command_out_ready_d;
      overrun           <= overrun_d;
      frame_error       <= frame_error_d;
    end
  end

  always_comb begin
    spi_miso = (state_q == StActive) & miso_sr_q[7];
  end

endmodule

// File: tb/tb_spi_command_receiver.sv
// Scoreboard bench for spi_command_receiver: the SPI host driver queues expected output events,
// a monitor pops and compares them whenever the DUT strobes an output.
module tb_spi_command_receiver;

  localparam int SyncStages = 2;
  localparam int Half       = 8;
  localparam int KindCmd    = 0;
  localparam int KindOvr    = 1;
  localparam int KindFe     = 2;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       spi_sclk, spi_cs_n, spi_mosi, spi_miso;
  logic [7:0] command_out;
  logic       command_out_ready, overrun, frame_error;
  logic [5:0] fifo_count;
  logic       invalid_command;

  typedef struct {
    int         kind;
    logic [7:0] val;
  } ev_t;

  ev_t        exp_q[$];
  ev_t        mon_e;
  int         mon_kind;
  int         n_checks = 0;
  int         n_fail = 0;
  longint     cyc = 0;
  longint     last_rise_cyc = 0;
  logic [7:0] rx;

  spi_command_receiver #(
    .spi_fifo_length(32),
    .count_width    (6),
    .sync_stages    (SyncStages)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .spi_sclk         (spi_sclk),
    .spi_cs_n         (spi_cs_n),
    .spi_mosi         (spi_mosi),
    .spi_miso         (spi_miso),
    .command_out      (command_out),
    .command_out_ready(command_out_ready),
    .fifo_count       (fifo_count),
    .invalid_command  (invalid_command),
    .overrun          (overrun),
    .frame_error      (frame_error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push(input int kind, input logic [7:0] val);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    exp_q.push_back(e);
  endtask

  // Monitor: every strobe must match the oldest queued expectation.
  always @(negedge clk) begin
    if (reset_n && (command_out_ready || overrun || frame_error)) begin
      mon_kind = command_out_ready ? KindCmd : (overrun ? KindOvr : KindFe);
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_event: got kind %0d (command_out 0x%0h), expected none",
                 mon_kind, command_out);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", mon_kind, mon_e.kind);
        if (mon_kind == KindCmd) check("command_out", {24'd0, command_out}, {24'd0, mon_e.val});
        if (mon_kind != KindFe) check("strobe_latency", 32'(cyc - last_rise_cyc), SyncStages + 2);
      end
    end
  end

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic spi_bits(input logic [7:0] tx, input int nbits, output logic [7:0] rx_o);
    rx_o = 8'd0;
    for (int i = 0; i < nbits; i++) begin
      spi_mosi = tx[7-i];
      wait_clk(Half);
      rx_o = {rx_o[6:0], spi_miso};
      spi_sclk = 1'b1;
      last_rise_cyc = cyc;
      wait_clk(Half);
      spi_sclk = 1'b0;
    end
  endtask

  task automatic send_byte(input logic [7:0] tx, input logic [7:0] exp_status, input string name);
    logic [7:0] r;
    spi_bits(tx, 8, r);
    check({name, "_status"}, {24'd0, r}, {24'd0, exp_status});
  endtask

  task automatic cs_low();
    spi_cs_n = 1'b0;
    wait_clk(Half);
  endtask

  task automatic cs_high();
    wait_clk(Half);
    spi_cs_n = 1'b1;
    wait_clk(Half);
  endtask

  task automatic check_reset_outputs(input string name);
    check({name, "_miso"}, {31'd0, spi_miso}, 0);
    check({name, "_command_out"}, {24'd0, command_out}, 0);
    check({name, "_ready"}, {31'd0, command_out_ready}, 0);
    check({name, "_overrun"}, {31'd0, overrun}, 0);
    check({name, "_frame_error"}, {31'd0, frame_error}, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n         = 1'b0;
    spi_sclk        = 1'b0;
    spi_cs_n        = 1'b1;
    spi_mosi        = 1'b0;
    fifo_count      = 6'd0;
    invalid_command = 1'b0;
    wait_clk(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    wait_clk(10);

    // Basic byte, empty FIFO, no flags.
    cs_low();
    push(KindCmd, 8'hA5);
    send_byte(8'hA5, 8'h00, "basic");
    cs_high();

    // FIFO full: byte dropped, overrun sticky reported then cleared.
    fifo_count = 6'd32;
    cs_low();
    push(KindOvr, 8'h00);
    send_byte(8'h3C, 8'h20, "full");
    cs_high();
    check("cmd_hold_overrun", {24'd0, command_out}, 32'hA5);
    cs_low();
    fifo_count = 6'd31;
    push(KindCmd, 8'h42);
    send_byte(8'h42, 8'h60, "ovr_flag");
    cs_high();
    fifo_count = 6'd32;
    cs_low();
    fifo_count = 6'd0;
    push(KindCmd, 8'h99);
    send_byte(8'h99, 8'h20, "ovr_cleared");
    cs_high();

    // Invalid flag reported once, then cleared within the same transfer.
    fifo_count = 6'd5;
    invalid_command = 1'b1;
    wait_clk(1);
    invalid_command = 1'b0;
    cs_low();
    push(KindCmd, 8'h12);
    send_byte(8'h12, 8'h85, "inv_flag");
    push(KindCmd, 8'h34);
    send_byte(8'h34, 8'h05, "inv_cleared");
    cs_high();

    // Frame error after 5 bits, then a clean byte.
    cs_low();
    spi_bits(8'hF0, 5, rx);
    push(KindFe, 8'h00);
    cs_high();
    check("cmd_hold_frame", {24'd0, command_out}, 32'h34);
    cs_low();
    push(KindCmd, 8'h11);
    send_byte(8'h11, 8'h05, "after_frame");
    cs_high();

    // Reset mid-byte with CS low: nothing accepted until CS rises.
    cs_low();
    spi_bits(8'hAA, 3, rx);
    reset_n = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    wait_clk(3);
    reset_n = 1'b1;
    spi_bits(8'hC3, 8, rx);
    spi_bits(8'h3C, 5, rx);
    check("cmd_after_rearm", {24'd0, command_out}, 0);
    cs_high();
    cs_low();
    push(KindCmd, 8'hFF);
    send_byte(8'hFF, 8'h05, "rearm0");
    push(KindCmd, 8'h00);
    send_byte(8'h00, 8'h05, "rearm1");
    push(KindCmd, 8'h7E);
    send_byte(8'h7E, 8'h05, "rearm2");
    cs_high();

    // SCLK rise coincident with CS fall must be ignored.
    spi_mosi = 1'b1;
    spi_cs_n = 1'b0;
    spi_sclk = 1'b1;
    wait_clk(Half);
    spi_sclk = 1'b0;
    wait_clk(Half);
    push(KindCmd, 8'h5A);
    send_byte(8'h5A, 8'h05, "coincident");
    cs_high();

    wait_clk(20);
    check("queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
